// File: rtl/cmat_pkg.sv
// Shared types and arithmetic helpers for the sequential complex matrix multiplier.
// Writeback helpers work on a 64-bit signed value wide enough for any legal accumulator.
package cmat_pkg;

    typedef enum logic [1:0] {IDLE, CALC, WB, DONE} state_t;

    function automatic int acc_w(input int data_w, input int common);
        return 2 * data_w + $clog2(common) + 1;
    endfunction

    // Round half up, then arithmetic shift right.
    function automatic logic signed [63:0] round_shr(input logic signed [63:0] acc, input int shift);
        logic signed [63:0] v;
        v = acc;
        if (shift > 0) v = v + (64'sd1 <<< (shift - 1));
        return v >>> shift;
    endfunction

    function automatic logic signed [63:0] sat_hi(input int data_w);
        return (64'sd1 <<< (data_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_lo(input int data_w);
        return -(64'sd1 <<< (data_w - 1));
    endfunction

    function automatic logic sat_ovf(input logic signed [63:0] v, input int data_w);
        return (v > sat_hi(data_w)) || (v < sat_lo(data_w));
    endfunction

    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int data_w);
        if (v > sat_hi(data_w)) return sat_hi(data_w);
        if (v < sat_lo(data_w)) return sat_lo(data_w);
        return v;
    endfunction

endpackage

// File: rtl/cmat_mult_seq_cmac_lane.sv
// One complex multiply-accumulate lane: four signed multipliers feeding re/im accumulators.
// Conjugation negates products rather than operands so the most negative input never overflows.
module cmac_lane #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 34
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     enable,
    input  logic                     conj_a,
    input  logic                     conj_b,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    output logic signed [ACC_W-1:0]  acc_re,
    output logic signed [ACC_W-1:0]  acc_im
);

    logic signed [2*DATA_W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [ACC_W-1:0]    t_rr, t_ii, t_ri, t_ir;

    assign p_rr = a_re * b_re;
    assign p_ii = a_im * b_im;
    assign p_ri = a_re * b_im;
    assign p_ir = a_im * b_re;

    assign t_rr = ACC_W'(p_rr);
    assign t_ii = ACC_W'(p_ii);
    assign t_ri = ACC_W'(p_ri);
    assign t_ir = ACC_W'(p_ir);

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (enable) begin
            acc_re <= acc_re + t_rr + ((conj_a ^ conj_b) ? t_ii : -t_ii);
            acc_im <= acc_im + (conj_b ? -t_ri : t_ri) + (conj_a ? -t_ir : t_ir);
        end
    end

endmodule

// File: rtl/cmat_mult_seq.sv
// Time-multiplexed complex matrix multiplier, LANES output elements per pass, valid/ready on both sides.
// Define CMAT_SAT_EN to saturate on writeback and report ovf; otherwise results wrap and ovf is 0.
module cmat_mult_seq
    import cmat_pkg::*;
#(
    parameter int OUT_ROW = 2,
    parameter int OUT_COL = 3,
    parameter int COMMON  = 2,
    parameter int LANES   = 1,
    parameter int DATA_W  = 16,
    parameter int SHIFT   = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  conj_a,
    input  logic                                  conj_b,
    input  logic [2*DATA_W*OUT_ROW*COMMON-1:0]    mat_a,
    input  logic [2*DATA_W*COMMON*OUT_COL-1:0]    mat_b,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [2*DATA_W*OUT_ROW*OUT_COL-1:0]   mat_out,
    output logic                                  ovf
);

    localparam int N_A   = OUT_ROW * COMMON;
    localparam int N_B   = COMMON * OUT_COL;
    localparam int N_O   = OUT_ROW * OUT_COL;
    localparam int G     = N_O / LANES;
    localparam int ACC_W = acc_w(DATA_W, COMMON);
    localparam int KW    = (COMMON > 1) ? $clog2(COMMON) : 1;
    localparam int GW    = (G > 1) ? $clog2(G) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(COMMON - 1);
    localparam logic [GW-1:0] G_LAST = GW'(G - 1);

    if (N_O % LANES != 0) begin : g_bad_lanes
        $error("LANES must divide OUT_ROW*OUT_COL");
    end
    if (SHIFT < 0 || SHIFT > DATA_W) begin : g_bad_shift
        $error("SHIFT must lie in 0..DATA_W");
    end

    state_t                 state, state_nx;
    logic [KW-1:0]          k;
    logic [GW-1:0]          g;
    logic [2*DATA_W*N_A-1:0] a_q;
    logic [2*DATA_W*N_B-1:0] b_q;
    logic                   ca_q, cb_q;
    logic                   accept;
    logic [LANES*DATA_W-1:0] wb_re, wb_im;

    assign in_ready  = rst && (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = CALC;
            CALC: if (k == K_LAST) state_nx = WB;
            WB:   state_nx = (g == G_LAST) ? DONE : CALC;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            k       <= '0;
            g       <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ca_q    <= 1'b0;
            cb_q    <= 1'b0;
            mat_out <= '0;
        end else begin
            if (accept) begin
                a_q  <= mat_a;
                b_q  <= mat_b;
                ca_q <= conj_a;
                cb_q <= conj_b;
                k    <= '0;
                g    <= '0;
            end
            if (state == CALC) k <= k + KW'(1);
            if (state == WB) begin
                k <= '0;
                if (g != G_LAST) g <= g + GW'(1);
                for (int l = 0; l < LANES; l++) begin
                    mat_out[(int'(g) * LANES + l) * DATA_W +: DATA_W]       <= wb_re[l*DATA_W +: DATA_W];
                    mat_out[(N_O + int'(g) * LANES + l) * DATA_W +: DATA_W] <= wb_im[l*DATA_W +: DATA_W];
                end
            end
        end
    end

`ifdef CMAT_SAT_EN
    logic [LANES-1:0] lane_ovf;
    logic             ovf_q;

    always_ff @(posedge clk) begin
        if (!rst)              ovf_q <= 1'b0;
        else if (accept)       ovf_q <= 1'b0;
        else if (state == WB)  ovf_q <= ovf_q | (|lane_ovf);
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
        logic signed [ACC_W-1:0]  acc_re, acc_im;
        logic signed [63:0]       v_re, v_im;
        logic [DATA_W-1:0]        r_re, r_im;

        // Element e sits at row e/OUT_COL, column e%OUT_COL; k walks the common dimension.
        always_comb begin
            int e, ia, ib;
            e    = int'(g) * LANES + l;
            ia   = (e / OUT_COL) * COMMON + int'(k);
            ib   = int'(k) * OUT_COL + (e % OUT_COL);
            a_re = a_q[ia * DATA_W +: DATA_W];
            a_im = a_q[(N_A + ia) * DATA_W +: DATA_W];
            b_re = b_q[ib * DATA_W +: DATA_W];
            b_im = b_q[(N_B + ib) * DATA_W +: DATA_W];
        end

        cmac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clear  (accept || (state == WB)),
            .enable (state == CALC),
            .conj_a (ca_q),
            .conj_b (cb_q),
            .a_re   (a_re),
            .a_im   (a_im),
            .b_re   (b_re),
            .b_im   (b_im),
            .acc_re (acc_re),
            .acc_im (acc_im)
        );

        assign v_re = round_shr(64'(acc_re), SHIFT);
        assign v_im = round_shr(64'(acc_im), SHIFT);

`ifdef CMAT_SAT_EN
        logic signed [63:0] c_re, c_im;
        assign c_re        = sat_clamp(v_re, DATA_W);
        assign c_im        = sat_clamp(v_im, DATA_W);
        assign r_re        = c_re[DATA_W-1:0];
        assign r_im        = c_im[DATA_W-1:0];
        assign lane_ovf[l] = sat_ovf(v_re, DATA_W) || sat_ovf(v_im, DATA_W);
`else
        assign r_re = v_re[DATA_W-1:0];
        assign r_im = v_im[DATA_W-1:0];
`endif

        assign wb_re[l*DATA_W +: DATA_W] = r_re;
        assign wb_im[l*DATA_W +: DATA_W] = r_im;
    end

endmodule

// File: tb/tb_cmat_mult_seq.sv
// Directed bench for cmat_mult_seq: one LANES=1 and one LANES=2 instance sharing operand buses.
module tb_cmat_mult_seq;

    localparam int DW = 16;

    typedef int m4_t[4];
    typedef int m6_t[6];
    typedef struct {
        m4_t a_re, a_im;
        m6_t b_re, b_im;
        bit  ca, cb;
        m6_t e_re, e_im;
        bit  e_ovf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         conj_a, conj_b;
    logic [127:0] mat_a;
    logic [191:0] mat_b;
    logic         in_valid1, in_ready1, out_valid1, out_ready1, ovf1;
    logic         in_valid2, in_ready2, out_valid2, out_ready2, ovf2;
    logic [191:0] mat_out1, mat_out2;

    vec_t vecs[6];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    cmat_mult_seq #(.OUT_ROW(2), .OUT_COL(3), .COMMON(2), .LANES(1), .DATA_W(DW), .SHIFT(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .conj_a(conj_a), .conj_b(conj_b), .mat_a(mat_a), .mat_b(mat_b),
        .out_valid(out_valid1), .out_ready(out_ready1), .mat_out(mat_out1), .ovf(ovf1));

    cmat_mult_seq #(.OUT_ROW(2), .OUT_COL(3), .COMMON(2), .LANES(2), .DATA_W(DW), .SHIFT(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .conj_a(conj_a), .conj_b(conj_b), .mat_a(mat_a), .mat_b(mat_b),
        .out_valid(out_valid2), .out_ready(out_ready2), .mat_out(mat_out2), .ovf(ovf2));

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [191:0] pack6(input m6_t re, input m6_t im);
        logic [191:0] r;
        for (int i = 0; i < 6; i++) begin
            r[i*DW +: DW]     = 16'(re[i]);
            r[(6+i)*DW +: DW] = 16'(im[i]);
        end
        return r;
    endfunction

    function automatic logic [127:0] pack4(input m4_t re, input m4_t im);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*DW +: DW]     = 16'(re[i]);
            r[(4+i)*DW +: DW] = 16'(im[i]);
        end
        return r;
    endfunction

    task automatic load(input int idx);
        mat_a  = pack4(vecs[idx].a_re, vecs[idx].a_im);
        mat_b  = pack6(vecs[idx].b_re, vecs[idx].b_im);
        conj_a = vecs[idx].ca;
        conj_b = vecs[idx].cb;
    endtask

    // Called at a negedge just after the accept edge; counts edges until out_valid.
    task automatic wait_result(input int which, input int idx, input int exp_lat, input string tag, input bit rel);
        int   n = 0;
        logic ov;
        ov = (which == 1) ? out_valid1 : out_valid2;
        while (!ov && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            ov = (which == 1) ? out_valid1 : out_valid2;
        end
        chk({tag, "_lat"}, 192'(n), 192'(exp_lat));
        chk({tag, "_out"}, (which == 1) ? mat_out1 : mat_out2, pack6(vecs[idx].e_re, vecs[idx].e_im));
        chk({tag, "_ovf"}, 192'((which == 1) ? ovf1 : ovf2), 192'(vecs[idx].e_ovf));
        if (rel) begin
            if (which == 1) out_ready1 = 1'b1; else out_ready2 = 1'b1;
            @(negedge clk);
            out_ready1 = 1'b0;
            out_ready2 = 1'b0;
        end
    endtask

    task automatic start(input int which, input int idx, input string tag);
        int   n = 0;
        logic rdy;
        load(idx);
        rdy = (which == 1) ? in_ready1 : in_ready2;
        while (!rdy && n < 50) begin
            @(negedge clk);
            n++;
            rdy = (which == 1) ? in_ready1 : in_ready2;
        end
        chk({tag, "_rdy"}, 192'(rdy), 192'(1));
        if (which == 1) in_valid1 = 1'b1; else in_valid2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
    endtask

    task automatic run_vec(input int which, input int idx, input int exp_lat, input string tag);
        start(which, idx, tag);
        wait_result(which, idx, exp_lat, tag, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // basic, conj_a, conj_b, both, negatives, saturation
        vecs[0].a_re = '{1, 2, 0, 3};   vecs[0].a_im = '{1, 0, 0, 0};
        vecs[0].b_re = '{1, 0, 0, 0, 1, 1}; vecs[0].b_im = '{0, 0, 1, 0, 0, 0};
        vecs[0].ca = 0; vecs[0].cb = 0;
        vecs[0].e_re = '{1, 2, 1, 0, 3, 3}; vecs[0].e_im = '{1, 0, 1, 0, 0, 0}; vecs[0].e_ovf = 0;
        vecs[1] = vecs[0]; vecs[1].ca = 1;
        vecs[1].e_re = '{1, 2, 3, 0, 3, 3}; vecs[1].e_im = '{-1, 0, 1, 0, 0, 0};
        vecs[2] = vecs[0]; vecs[2].cb = 1;
        vecs[2].e_re = '{1, 2, 3, 0, 3, 3}; vecs[2].e_im = '{1, 0, -1, 0, 0, 0};
        vecs[3] = vecs[0]; vecs[3].ca = 1; vecs[3].cb = 1;
        vecs[3].e_re = '{1, 2, 1, 0, 3, 3}; vecs[3].e_im = '{-1, 0, -1, 0, 0, 0};
        vecs[4].a_re = '{-2, 0, 1, 0};  vecs[4].a_im = '{0, 3, -1, 0};
        vecs[4].b_re = '{1, -1, 0, 2, 0, 0}; vecs[4].b_im = '{2, 0, 0, 0, 0, -3};
        vecs[4].ca = 0; vecs[4].cb = 0;
        vecs[4].e_re = '{-2, 2, 9, 3, -1, 0}; vecs[4].e_im = '{2, 0, 0, 1, 1, 0}; vecs[4].e_ovf = 0;
        vecs[5].a_re = '{32767, 32767, 0, 0}; vecs[5].a_im = '{0, 0, 0, 0};
        vecs[5].b_re = '{32767, 0, 0, 32767, 0, 0}; vecs[5].b_im = '{0, 0, 0, 0, 0, 0};
        vecs[5].ca = 0; vecs[5].cb = 0;
        vecs[5].e_im = '{0, 0, 0, 0, 0, 0};
`ifdef CMAT_SAT_EN
        vecs[5].e_re = '{32767, 0, 0, 0, 0, 0}; vecs[5].e_ovf = 1;
`else
        vecs[5].e_re = '{2, 0, 0, 0, 0, 0}; vecs[5].e_ovf = 0;
`endif

        rst = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b0;
        load(0);
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 192'(in_ready1), 192'(0));
        chk("rst_out_valid", 192'(out_valid1), 192'(0));
        chk("rst_mat_out", mat_out1, 192'(0));
        chk("rst_ovf", 192'(ovf1), 192'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 192'(in_ready1), 192'(1));

        run_vec(1, 0, 18, "basic");
        run_vec(1, 1, 18, "conj_a");
        run_vec(1, 2, 18, "conj_b");
        run_vec(1, 3, 18, "conj_ab");
        run_vec(1, 4, 18, "negative");
        run_vec(1, 5, 18, "saturate");

        // Back-pressure: result must hold while new data waits on in_valid.
        start(1, 0, "bp");
        wait_result(1, 0, 18, "bp_first", 1'b0);
        load(1);
        in_valid1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_out", mat_out1, pack6(vecs[0].e_re, vecs[0].e_im));
            chk("bp_hold_valid", 192'(out_valid1), 192'(1));
            chk("bp_hold_ready", 192'(in_ready1), 192'(0));
        end
        out_ready1 = 1'b1;
        @(negedge clk);
        chk("bp_idle_valid", 192'(out_valid1), 192'(0));
        chk("bp_idle_ready", 192'(in_ready1), 192'(1));
        out_ready1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        wait_result(1, 1, 18, "bp_second", 1'b1);

        // Reset at k=1 of group 2; groups 0 and 1 already overwrote elements 0 and 1.
        start(1, 0, "rst_mid");
        repeat (7) @(negedge clk);
        chk("partial_out", mat_out1, pack6('{1, 2, 3, 0, 3, 3}, '{1, 0, 1, 0, 0, 0}));
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 192'(out_valid1), 192'(0));
        chk("rst_mid_out", mat_out1, 192'(0));
        chk("rst_mid_ready", 192'(in_ready1), 192'(0));
        rst = 1'b1;
        run_vec(1, 2, 18, "after_rst");

        run_vec(2, 0, 9, "lanes2_basic");
        run_vec(2, 4, 9, "lanes2_neg");
        run_vec(2, 1, 9, "lanes2_conj_a");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
